ps2_scan_ctrl: RTL and testbench

//  Sequencer behind the PS/2 byte receiver: takes its validated 8-bit codes plus one-cycle strobe.

---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_evt_fifo.sv | 54 +++++
 rtl/ps2_scan_ctrl.sv | 177 +++++++++++++++++
 tb/tb_ps2_scan_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 scan-code sequencer.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_E0   = 2'd1,
    GOT_F0   = 2'd2,
    GOT_E0F0 = 2'd3
  } dec_state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through FIFO of key events; head reads as zero while empty.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  ps2_evt_t din,
  input  logic     pop,
  output ps2_evt_t dout,
  output logic     full,
  output logic     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  ps2_evt_t    mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

  assign dout = empty ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/ps2_scan_ctrl.sv
// PS/2 scan-code sequencer: strips E0/F0 prefixes into make/break events, queues them.
// Optional auto-repeat suppression is built when PS2_TYPEMATIC_FILTER_EN is defined.
module ps2_scan_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] key_cnt,
  output logic       overflow,
  input  logic       clr
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  dec_state_t  state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0]  key_cnt_q, key_cnt_d;
  logic        overflow_q, overflow_d;

  logic        emit, drop, push, pop, full, empty, accepted;
  ps2_evt_t    evt, head;

  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    emit     = 1'b0;
    evt.code = rx_data;
    evt.ext  = 1'b0;
    evt.brk  = 1'b0;
    if (rx_valid) begin
      tcnt_d = '0;
      unique case (state_q)
        IDLE: begin
          if (rx_data == PS2_EXT)      state_d = GOT_E0;
          else if (rx_data == PS2_BRK) state_d = GOT_F0;
          else                         emit = 1'b1;
        end
        GOT_E0: begin
          if (rx_data == PS2_BRK) state_d = GOT_E0F0;
          else if (rx_data != PS2_EXT) begin
            emit    = 1'b1;
            evt.ext = 1'b1;
            state_d = IDLE;
          end
        end
        GOT_F0: begin
          if (rx_data == PS2_EXT) state_d = GOT_E0F0;
          else if (rx_data != PS2_BRK) begin
            emit    = 1'b1;
            evt.brk = 1'b1;
            state_d = IDLE;
          end
        end
        GOT_E0F0: begin
          if (rx_data != PS2_EXT && rx_data != PS2_BRK) begin
            emit    = 1'b1;
            evt.ext = 1'b1;
            evt.brk = 1'b1;
            state_d = IDLE;
          end
        end
      endcase
    end else if (state_q != IDLE) begin
      // A stalled prefix is abandoned silently once the idle budget is spent.
      if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d = IDLE;
        tcnt_d  = '0;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [7:0] last_code_q, last_code_d;
  logic       last_ext_q, last_ext_d;
  logic       held_q, held_d;
  logic       same_key;

  assign same_key = held_q && (last_code_q == evt.code) && (last_ext_q == evt.ext);

  always_comb begin
    last_code_d = last_code_q;
    last_ext_d  = last_ext_q;
    held_d      = held_q;
    drop        = 1'b0;
    if (emit) begin
      if (!evt.brk) begin
        if (same_key) begin
          drop = 1'b1;
        end else begin
          held_d      = 1'b1;
          last_code_d = evt.code;
          last_ext_d  = evt.ext;
        end
      end else if (same_key) begin
        held_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_code_q <= '0;
      last_ext_q  <= 1'b0;
      held_q      <= 1'b0;
    end else begin
      last_code_q <= last_code_d;
      last_ext_q  <= last_ext_d;
      held_q      <= held_d;
    end
  end
`else
  assign drop = 1'b0;
`endif

  assign push     = emit & ~drop;
  assign pop      = evt_valid & evt_ready;
  assign accepted = push & (~full | pop);

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (evt),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    key_cnt_d  = key_cnt_q;
    overflow_d = overflow_q;
    if (clr) begin
      key_cnt_d  = '0;
      overflow_d = 1'b0;
    end else begin
      if (accepted && !evt.brk) key_cnt_d = key_cnt_q + 1'b1;
      if (push && !accepted)    overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tcnt_q     <= '0;
      key_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      key_cnt_q  <= key_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign evt_valid = ~empty;
  assign evt_code  = head.code;
  assign evt_ext   = head.ext;
  assign evt_break = head.brk;
  assign key_cnt   = key_cnt_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Bench for ps2_scan_ctrl: directed scenarios plus random traffic against a queue-based model.
module tb_ps2_scan_ctrl;

  localparam int DEPTH = 8;
  localparam int TO    = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] key_cnt;
  logic       overflow;
  logic       clr;

  int checks = 0;
  int errors = 0;

  // Reference model: events as {code, ext, brk}
  logic [9:0] q[$];
  logic [7:0] m_cnt;
  bit         m_ovf;
  bit         m_pre, m_ext, m_brk;
  int         m_idle;
  bit         m_held;
  logic [8:0] m_key;

  ps2_scan_ctrl #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .evt_code  (evt_code),
    .evt_ext   (evt_ext),
    .evt_break (evt_break),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .key_cnt   (key_cnt),
    .overflow  (overflow),
    .clr       (clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cnt  = '0;
    m_ovf  = 0;
    m_pre  = 0;
    m_ext  = 0;
    m_brk  = 0;
    m_idle = 0;
    m_held = 0;
    m_key  = '0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit r, input bit c);
    bit         pop, emit, drop;
    logic [9:0] ev;
    pop  = r && q.size() > 0;
    emit = 0;
    drop = 0;
    ev   = '0;
    if (v) begin
      m_idle = 0;
      if (d == 8'hE0) begin
        m_pre = 1; m_ext = 1;
      end else if (d == 8'hF0) begin
        m_pre = 1; m_brk = 1;
      end else begin
        emit = 1;
        ev   = {d, m_ext, m_brk};
        m_pre = 0; m_ext = 0; m_brk = 0;
      end
    end else if (m_pre) begin
      m_idle++;
      if (m_idle == TO) begin
        m_pre = 0; m_ext = 0; m_brk = 0; m_idle = 0;
      end
    end
`ifdef PS2_TYPEMATIC_FILTER_EN
    if (emit) begin
      if (!ev[0]) begin
        if (m_held && m_key == ev[9:1]) drop = 1;
        else begin
          m_held = 1; m_key = ev[9:1];
        end
      end else if (m_held && m_key == ev[9:1]) begin
        m_held = 0;
      end
    end
`endif
    if (pop) void'(q.pop_front());
    if (emit && !drop) begin
      if (q.size() < DEPTH) begin
        q.push_back(ev);
        if (!ev[0]) m_cnt = m_cnt + 8'd1;
      end else begin
        m_ovf = 1;
      end
    end
    if (c) begin
      m_cnt = '0;
      m_ovf = 0;
    end
  endtask

  task automatic check_all();
    logic [9:0] h;
    h = (q.size() > 0) ? q[0] : 10'h0;
    chk("evt_valid", 32'(evt_valid), 32'(q.size() > 0));
    chk("evt_code", 32'(evt_code), 32'(h[9:2]));
    chk("evt_ext", 32'(evt_ext), 32'(h[1]));
    chk("evt_break", 32'(evt_break), 32'(h[0]));
    chk("key_cnt", 32'(key_cnt), 32'(m_cnt));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // One clock: drive, clock, update model, compare just after the edge.
  task automatic cyc(input bit v, input logic [7:0] d, input bit r, input bit c);
    rx_valid  = v;
    rx_data   = d;
    evt_ready = r;
    clr       = c;
    @(posedge clk);
    model_step(v, d, r, c);
    #1;
    check_all();
    rx_valid = 0;
    clr      = 0;
  endtask

  task automatic rx(input logic [7:0] d);
    cyc(1, d, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) cyc(0, 8'h00, 1, 0);
    chk("drain_empty", 32'(evt_valid), 32'(0));
  endtask

  task automatic pulse_reset();
    #2 rst_n = 0;
    #2;
    model_reset();
    check_all();
    #2 rst_n = 1;
  endtask

  initial begin
    rst_n     = 0;
    rx_data   = '0;
    rx_valid  = 0;
    evt_ready = 0;
    clr       = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1;

    // 1: plain make, one-cycle latency
    rx(8'h1C);
    chk("t1_head", 32'({evt_valid, evt_code, evt_ext, evt_break}), 32'({1'b1, 8'h1C, 2'b00}));
    chk("t1_cnt", 32'(key_cnt), 32'(1));
    drain();

    // 2: break
    rx(8'hF0);
    chk("t2_no_evt_on_prefix", 32'(evt_valid), 32'(0));
    rx(8'h1C);
    chk("t2_head", 32'({evt_code, evt_ext, evt_break}), 32'({8'h1C, 2'b01}));
    chk("t2_cnt", 32'(key_cnt), 32'(1));
    cyc(0, 8'h00, 1, 0);
    chk("t2_single", 32'(evt_valid), 32'(0));

    // 3: extended break then extended make
    rx(8'hE0); rx(8'hF0); rx(8'h75);
    chk("t3_brk", 32'({evt_code, evt_ext, evt_break}), 32'({8'h75, 2'b11}));
    cyc(0, 8'h00, 1, 0);
    rx(8'hE0); rx(8'h75);
    chk("t3_make", 32'({evt_code, evt_ext, evt_break}), 32'({8'h75, 2'b10}));
    drain();

    // 4: overflow on full FIFO, in-order drain, clear
    cyc(0, 8'h00, 0, 1);
    for (int i = 0; i < 9; i++) rx(8'h15 + 8'(i));
    chk("t4_ovf", 32'(overflow), 32'(1));
    chk("t4_cnt", 32'(key_cnt), 32'(8));
    for (int i = 0; i < 8; i++) begin
      chk("t4_order", 32'(evt_code), 32'(8'h15 + 8'(i)));
      cyc(0, 8'h00, 1, 0);
    end
    chk("t4_empty", 32'(evt_valid), 32'(0));
    cyc(0, 8'h00, 0, 1);
    chk("t4_clr", 32'({key_cnt, overflow}), 32'(0));

    // Full FIFO with simultaneous pop: no overflow
    for (int i = 0; i < 8; i++) rx(8'h30 + 8'(i));
    cyc(1, 8'h40, 1, 0);
    chk("t4_fullpop_ovf", 32'(overflow), 32'(0));
    chk("t4_fullpop_cnt", 32'(key_cnt), 32'(9));
    // clr beats same-cycle increment, event still pushed
    cyc(1, 8'h41, 1, 1);
    chk("t4_clr_prio", 32'(key_cnt), 32'(0));
    drain();

    // 5: prefix timeout, and a prefix that survives just under the limit
    rx(8'hE0);
    repeat (TO + 1) cyc(0, 8'h00, 0, 0);
    rx(8'h1C);
    chk("t5_timeout", 32'({evt_code, evt_ext, evt_break}), 32'({8'h1C, 2'b00}));
    drain();
    rx(8'hE0);
    repeat (TO - 5) cyc(0, 8'h00, 0, 0);
    rx(8'h1C);
    chk("t5_no_timeout", 32'({evt_code, evt_ext, evt_break}), 32'({8'h1C, 2'b10}));
    drain();

    // 6: reset mid-prefix with queued events
    rx(8'h21); rx(8'h22); rx(8'h23); rx(8'hF0);
    pulse_reset();
    chk("t6_rst", 32'({evt_valid, key_cnt, overflow}), 32'(0));
    rx(8'h1C);
    chk("t6_after", 32'({evt_code, evt_ext, evt_break}), 32'({8'h1C, 2'b00}));
    drain();

`ifdef PS2_TYPEMATIC_FILTER_EN
    cyc(0, 8'h00, 0, 1);
    rx(8'h1C); rx(8'h1C); rx(8'h1C); rx(8'hF0); rx(8'h1C);
    chk("flt_cnt", 32'(key_cnt), 32'(1));
    chk("flt_first", 32'({evt_code, evt_ext, evt_break}), 32'({8'h1C, 2'b00}));
    cyc(0, 8'h00, 1, 0);
    chk("flt_second", 32'({evt_code, evt_ext, evt_break}), 32'({8'h1C, 2'b01}));
    cyc(0, 8'h00, 1, 0);
    chk("flt_only_two", 32'(evt_valid), 32'(0));
`endif

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      int unsigned sel;
      logic [7:0]  d;
      sel = $urandom_range(0, 9);
      if (sel < 2)      d = 8'hE0;
      else if (sel < 4) d = 8'hF0;
      else              d = 8'($urandom_range(1, 8'h7F));
      cyc(1'($urandom_range(0, 1)), d, $urandom_range(0, 3) == 0 ? 1'b0 : 1'($urandom_range(0, 1)),
          $urandom_range(0, 39) == 0);
      if (i == 400) pulse_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
